// File: rtl/alu_shift_hilo_unit.sv
// MIPS shift / HI-LO post-stage with an iterative shift-add multiplier and
// restoring divider that own HI/LO; results leave through a valid pulse.
module alu_shift_hilo_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op_class,
  input  logic [5:0]         funct,
  input  logic [SHAMT_W-1:0] sa,
  input  logic [WIDTH-1:0]   rs_val,
  input  logic [WIDTH-1:0]   rt_val,
  input  logic [WIDTH-1:0]   alu_in,
  output logic               out_valid,
  output logic [WIDTH-1:0]   result,
  output logic               busy,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH-1:0]   acc_hi, acc_lo, opnd, dividend_raw;
  logic               is_div, neg_lo, neg_hi, div_zero;

  logic               accept, is_r, is_md, md_signed;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [SHAMT_W-1:0] amt;
  logic [WIDTH-1:0]   single_res;
  logic [WIDTH:0]     sum, shifted;
  logic [WIDTH-1:0]   diff;
  logic               ge;
  logic [WIDTH-1:0]   next_hi, next_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign accept    = in_valid && in_ready;
  assign is_r      = (op_class == 2'b10);
  assign is_md     = is_r && (funct[5:2] == 4'b0110);
  assign md_signed = ~funct[0];
  assign mag_a     = (md_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign mag_b     = (md_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

  always_comb begin
    amt        = funct[2] ? rs_val[SHAMT_W-1:0] : sa;
    single_res = alu_in;
    if (is_r) begin
      case (funct)
        6'b000000, 6'b000100: single_res = rt_val << amt;
        6'b000010, 6'b000110: single_res = rt_val >> amt;
        6'b000011, 6'b000111: single_res = $signed(rt_val) >>> amt;
        6'b010000:            single_res = hi;
        6'b010010:            single_res = lo;
        6'b010001, 6'b010011: single_res = rs_val;
        default:              single_res = alu_in;
      endcase
    end
  end

  // acc_hi/acc_lo hold {partial product, multiplier} for mult and
  // {partial remainder, dividend->quotient} for div; opnd is the other operand.
  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    ge      = (shifted >= {1'b0, opnd});
    diff    = shifted[WIDTH-1:0] - opnd;
    if (is_div) begin
      next_hi = ge ? diff : shifted[WIDTH-1:0];
      next_lo = {acc_lo[WIDTH-2:0], ge};
    end else begin
      next_hi = sum[WIDTH:1];
      next_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_fix = neg_lo ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    if (!is_div) begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end else if (div_zero) begin
      fix_hi = dividend_raw;
      fix_lo = '1;
    end else begin
      fix_hi = neg_hi ? -acc_hi : acc_hi;
      fix_lo = neg_lo ? -acc_lo : acc_lo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      acc_hi       <= '0;
      acc_lo       <= '0;
      opnd         <= '0;
      dividend_raw <= '0;
      is_div       <= 1'b0;
      neg_lo       <= 1'b0;
      neg_hi       <= 1'b0;
      div_zero     <= 1'b0;
      in_ready     <= 1'b1;
      busy         <= 1'b0;
      out_valid    <= 1'b0;
      result       <= '0;
      hi           <= '0;
      lo           <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_md) begin
              state        <= RUN;
              cnt          <= '0;
              in_ready     <= 1'b0;
              busy         <= 1'b1;
              is_div       <= funct[1];
              acc_hi       <= '0;
              acc_lo       <= funct[1] ? mag_a : mag_b;
              opnd         <= funct[1] ? mag_b : mag_a;
              dividend_raw <= rs_val;
              div_zero     <= funct[1] && (rt_val == '0);
              neg_lo       <= md_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
              neg_hi       <= md_signed && rs_val[WIDTH-1];
            end else begin
              out_valid <= 1'b1;
              result    <= single_res;
              if (is_r && funct == 6'b010001) hi <= rs_val;
              if (is_r && funct == 6'b010011) lo <= rs_val;
            end
          end
        end
        RUN: begin
          acc_hi <= next_hi;
          acc_lo <= next_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == SHAMT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          hi        <= fix_hi;
          lo        <= fix_lo;
          result    <= fix_lo;
          out_valid <= 1'b1;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
